// File: rtl/traffic_phase_sequencer.sv
// Two-road traffic light sequencer driven by a one-second tick, realigning the tick divider on every phase change.
// Optional pedestrian walk feature enabled by defining PED_REQUEST_EN.
module traffic_phase_sequencer #(
  parameter logic [7:0] GREEN_SECS     = 8'd10,
  parameter logic [7:0] YELLOW_SECS    = 8'd3,
  parameter logic [7:0] RED_CLEAR_SECS = 8'd1,
  parameter logic [7:0] MIN_GREEN_SECS = 8'd4,
  parameter logic [7:0] WALK_SECS      = 8'd5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable_input,
`ifdef PED_REQUEST_EN
  input  logic       ped_request,
  output logic       ped_walk,
`endif
  output logic       divider_reset,
  output logic [2:0] ns_lights,
  output logic [2:0] ew_lights,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    RED_A     = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    RED_B     = 3'd5
  } state_t;

  // A zero-second duration behaves as one second.
  function automatic logic [7:0] term_of(input logic [7:0] secs);
    return (secs == 8'd0) ? 8'd0 : secs - 8'd1;
  endfunction

  function automatic logic [5:0] lamps_of(input state_t s);
    logic [5:0] l;
    case (s)
      NS_GREEN:  l = {3'b001, 3'b100};
      NS_YELLOW: l = {3'b010, 3'b100};
      EW_GREEN:  l = {3'b100, 3'b001};
      EW_YELLOW: l = {3'b100, 3'b010};
      default:   l = {3'b100, 3'b100};
    endcase
    return l;
  endfunction

  localparam logic [7:0] GREEN_TERM     = term_of(GREEN_SECS);
  localparam logic [7:0] YELLOW_TERM    = term_of(YELLOW_SECS);
  localparam logic [7:0] RED_CLEAR_TERM = term_of(RED_CLEAR_SECS);
  localparam logic [7:0] MIN_GREEN_TERM = term_of(MIN_GREEN_SECS);
  localparam logic [7:0] WALK_TERM      = term_of(WALK_SECS);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] sec_count;
  logic [7:0] term;
  logic       tick_ok;
  logic       phase_end;
  logic       illegal;
  logic       in_green;
  logic       in_yellow;
  logic       green_short;
  logic       red_walk;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    state_nxt = RED_B;
    term      = 8'd0;
    illegal   = 1'b0;
    in_green  = 1'b0;
    in_yellow = 1'b0;
    case (state)
      NS_GREEN:  begin state_nxt = NS_YELLOW; in_green = 1'b1;
                       term = green_short ? MIN_GREEN_TERM : GREEN_TERM; end
      NS_YELLOW: begin state_nxt = RED_A; in_yellow = 1'b1; term = YELLOW_TERM; end
      RED_A:     begin state_nxt = EW_GREEN; term = red_walk ? WALK_TERM : RED_CLEAR_TERM; end
      EW_GREEN:  begin state_nxt = EW_YELLOW; in_green = 1'b1;
                       term = green_short ? MIN_GREEN_TERM : GREEN_TERM; end
      EW_YELLOW: begin state_nxt = RED_B; in_yellow = 1'b1; term = YELLOW_TERM; end
      RED_B:     begin state_nxt = NS_GREEN; term = red_walk ? WALK_TERM : RED_CLEAR_TERM; end
      default:   illegal = 1'b1;
    endcase
    // Ticks landing while the divider is being realigned belong to no phase.
    tick_ok   = enable_input & ~divider_reset;
    // >= lets a green already past a shortened terminal end on the next tick.
    phase_end = illegal | (tick_ok & (sec_count >= term));
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
    if (!reset_n) begin
      state         <= RED_B;
      sec_count     <= 8'd0;
      divider_reset <= 1'b1;
      ns_lights     <= 3'b100;
      ew_lights     <= 3'b100;
    end else begin
      divider_reset <= phase_end;
      if (phase_end) begin
        state                  <= state_nxt;
        sec_count              <= 8'd0;
        {ns_lights, ew_lights} <= lamps_of(state_nxt);
      end else if (tick_ok) begin
        sec_count <= sec_count + 8'd1;
      end
    end
  end

  assign phase = state;

`ifdef PED_REQUEST_EN
  logic ped_latch;
  logic walk_pending;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ped_latch    <= 1'b0;
      walk_pending <= 1'b0;
      ped_walk     <= 1'b0;
    end else begin
      // A new request wins over the clear on entry to the walk phase.
      ped_latch <= ped_request | (ped_latch & ~(phase_end & in_yellow & walk_pending));
      if (phase_end) begin
        walk_pending <= in_green & ped_latch;
        ped_walk     <= in_yellow & walk_pending;
      end
    end
  end

  assign green_short = ped_latch;
  assign red_walk    = ped_walk;
`else
  assign green_short = 1'b0;
  assign red_walk    = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer, with a small tick-divider model closing the enable/reset handshake.
// Pedestrian sequences are built only when PED_REQUEST_EN is defined.
module tb_traffic_phase_sequencer;

  logic       clk;
  logic       reset_n;
  logic       enable_input;
  logic       divider_reset;
  logic [2:0] ns_lights;
  logic [2:0] ew_lights;
  logic [2:0] phase;
`ifdef PED_REQUEST_EN
  logic       ped_request;
  logic       ped_walk;
`endif

  int   n_cmp;
  int   n_fail;
  logic auto_div;
  logic manual_en;
  int   div_cnt;

  typedef struct {
    logic [2:0] ph;
    logic [2:0] ns;
    logic [2:0] ew;
    int         secs;
  } phase_rec_t;

  phase_rec_t tbl[6];

  traffic_phase_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable_input (enable_input),
`ifdef PED_REQUEST_EN
    .ped_request  (ped_request),
    .ped_walk     (ped_walk),
`endif
    .divider_reset(divider_reset),
    .ns_lights    (ns_lights),
    .ew_lights    (ew_lights),
    .phase        (phase)
  );

  initial begin : clock_gen
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Divide-by-4 tick source that restarts whenever divider_reset is high.
  initial begin : divider_model
    enable_input = 1'b0;
    div_cnt      = 0;
    forever begin
      @(negedge clk);
      #1;
      if (divider_reset === 1'b1) div_cnt = 0;
      else div_cnt = (div_cnt == 3) ? 0 : div_cnt + 1;
      enable_input = auto_div ? (div_cnt == 3) : manual_en;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_phase(input logic [2:0] ph, input string name);
    int n = 0;
    while (phase !== ph && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(name, {29'd0, phase}, {29'd0, ph});
  endtask

  // Counts clock cycles until phase leaves ph, and how many of them had divider_reset high.
  task automatic measure_phase(input logic [2:0] ph, output int cycles, output int dr_high);
    cycles  = 0;
    dr_high = (divider_reset === 1'b1) ? 1 : 0;
    while (phase === ph && cycles < 2000) begin
      @(negedge clk);
      cycles++;
      if (phase === ph && divider_reset === 1'b1) dr_high++;
    end
  endtask

  initial begin : main
    int cyc;
    int drh;
    int viol;
    int ns_entries;
    logic [2:0] prev_phase;

    n_cmp  = 0;
    n_fail = 0;
    tbl[0] = '{3'd0, 3'b001, 3'b100, 10};
    tbl[1] = '{3'd1, 3'b010, 3'b100, 3};
    tbl[2] = '{3'd2, 3'b100, 3'b100, 1};
    tbl[3] = '{3'd3, 3'b100, 3'b001, 10};
    tbl[4] = '{3'd4, 3'b100, 3'b010, 3};
    tbl[5] = '{3'd5, 3'b100, 3'b100, 1};

`ifdef PED_REQUEST_EN
    ped_request = 1'b0;
`endif
    reset_n   = 1'b0;
    auto_div  = 1'b0;
    manual_en = 1'b0;

    // Reset held for three cycles, with a tick arriving during it.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      manual_en = (i == 0);
      @(negedge clk);
      check("rst_phase", {29'd0, phase}, 32'd5);
      check("rst_ns", {29'd0, ns_lights}, 32'b100);
      check("rst_ew", {29'd0, ew_lights}, 32'b100);
      check("rst_divider_reset", {31'd0, divider_reset}, 32'd1);
    end

    // Tick on the first cycle after release is swallowed by the reset-held divider_reset.
    reset_n   = 1'b1;
    manual_en = 1'b1;
    @(negedge clk);
    check("rel_tick_phase", {29'd0, phase}, 32'd5);
    check("rel_tick_count", {24'd0, dut.sec_count}, 32'd0);
    check("rel_tick_dr", {31'd0, divider_reset}, 32'd0);
    manual_en = 1'b0;
    @(negedge clk);
    check("rel_idle_phase", {29'd0, phase}, 32'd5);
    manual_en = 1'b1;
    @(negedge clk);
    check("first_green_phase", {29'd0, phase}, 32'd0);
    check("first_green_ns", {29'd0, ns_lights}, 32'b001);
    check("first_green_dr", {31'd0, divider_reset}, 32'd1);
    @(negedge clk);
    check("dr_tick_ignored_count", {24'd0, dut.sec_count}, 32'd0);
    check("dr_tick_ignored_dr", {31'd0, divider_reset}, 32'd0);
    @(negedge clk);
    check("tick_accepted_count", {24'd0, dut.sec_count}, 32'd1);
    manual_en = 1'b0;

    // Full cycle with the divider model: one tick every 4 cycles.
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    auto_div = 1'b1;
    reset_n  = 1'b1;
    measure_phase(3'd5, cyc, drh);
    check("boot_red_cycles", cyc, 32'd4);
    check("boot_red_dr_width", drh, 32'd1);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("seq%0d_phase", i), {29'd0, phase}, {29'd0, tbl[i].ph});
      check($sformatf("seq%0d_ns", i), {29'd0, ns_lights}, {29'd0, tbl[i].ns});
      check($sformatf("seq%0d_ew", i), {29'd0, ew_lights}, {29'd0, tbl[i].ew});
      measure_phase(tbl[i].ph, cyc, drh);
      check($sformatf("seq%0d_cycles", i), cyc, 4 * tbl[i].secs);
      check($sformatf("seq%0d_dr_width", i), drh, 32'd1);
    end

    // Reset in the middle of EW_GREEN at sec_count 6.
    wait_phase(3'd3, "mid_wait_ew_green");
    repeat (24) @(negedge clk);
    check("mid_count", {24'd0, dut.sec_count}, 32'd6);
    check("mid_phase_before", {29'd0, phase}, 32'd3);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_phase", {29'd0, phase}, 32'd5);
    check("mid_rst_ns", {29'd0, ns_lights}, 32'b100);
    check("mid_rst_ew", {29'd0, ew_lights}, 32'b100);
    check("mid_rst_dr", {31'd0, divider_reset}, 32'd1);

    // 1000 seconds of lamp safety; 36 NS_GREEN entries fit in 4000 cycles.
    reset_n    = 1'b1;
    viol       = 0;
    ns_entries = 0;
    prev_phase = 3'd5;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (!$onehot(ns_lights) || !$onehot(ew_lights)) viol++;
      if (ns_lights !== 3'b100 && ew_lights !== 3'b100) viol++;
      if (phase === 3'd0 && prev_phase !== 3'd0) ns_entries++;
      prev_phase = phase;
    end
    check("safety_violations", viol, 32'd0);
    check("safety_ns_green_entries", ns_entries, 32'd36);

`ifdef PED_REQUEST_EN
    // Request at NS_GREEN sec 1: 4 s green, 3 s yellow, 5 s walk on RED_A.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    wait_phase(3'd0, "ped1_wait_ns_green");
    repeat (4) @(negedge clk);
    check("ped1_count", {24'd0, dut.sec_count}, 32'd1);
    ped_request = 1'b1;
    @(negedge clk);
    ped_request = 1'b0;
    measure_phase(3'd0, cyc, drh);
    check("ped1_green_cycles", cyc + 5, 32'd16);
    check("ped1_yellow_phase", {29'd0, phase}, 32'd1);
    measure_phase(3'd1, cyc, drh);
    check("ped1_yellow_cycles", cyc, 32'd12);
    check("ped1_walk_phase", {29'd0, phase}, 32'd2);
    check("ped1_walk_on", {31'd0, ped_walk}, 32'd1);
    measure_phase(3'd2, cyc, drh);
    check("ped1_walk_cycles", cyc, 32'd20);
    check("ped1_ew_green_phase", {29'd0, phase}, 32'd3);
    check("ped1_walk_off", {31'd0, ped_walk}, 32'd0);

    // Request at EW_GREEN sec 7, already past the shortened terminal: ends on the next tick.
    repeat (28) @(negedge clk);
    check("ped2_count", {24'd0, dut.sec_count}, 32'd7);
    ped_request = 1'b1;
    @(negedge clk);
    ped_request = 1'b0;
    measure_phase(3'd3, cyc, drh);
    check("ped2_green_cycles", cyc + 29, 32'd32);
    measure_phase(3'd4, cyc, drh);
    check("ped2_yellow_cycles", cyc, 32'd12);
    check("ped2_walk_on", {31'd0, ped_walk}, 32'd1);
    measure_phase(3'd5, cyc, drh);
    check("ped2_walk_cycles", cyc, 32'd20);
    check("ped2_walk_off", {31'd0, ped_walk}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
